// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_pkg;

    typedef enum logic {
        CD_IDLE = 1'b0,
        CD_RUN  = 1'b1
    } cd_state_t;

    localparam int CD_WIDTH_DEFAULT = 8;

endpackage : countdown_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter that pulses done on expiry; one-shot by default,
// periodic when COUNTDOWN_AUTO_RELOAD_EN is defined.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    cd_state_t        state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Next-state logic: clear > load > enabled decrement > hold.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        done_d   = 1'b0;
        if (count_clr) begin
            state_d  = CD_IDLE;
            count_d  = CNT_ZERO;
            period_d = CNT_ZERO;
        end else if (load) begin
            count_d  = load_val;
            period_d = load_val;
            if (load_val != CNT_ZERO) begin
                state_d = CD_RUN;
            end else begin
                // A zero period expires on the spot.
                state_d = CD_IDLE;
                done_d  = 1'b1;
            end
        end else if ((state_q == CD_RUN) && count_en) begin
            if (count_q == CNT_ONE) begin
                done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count_d = period_q;
                state_d = CD_RUN;
`else
                count_d = CNT_ZERO;
                state_d = CD_IDLE;
`endif
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d == CD_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CD_IDLE;
            count_q  <= CNT_ZERO;
            period_q <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign zero  = (count_q == CNT_ZERO);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: each scenario queues stimulus with
// its expected outputs, then replays them cycle by cycle and compares.
module tb_countdown_timer;

    typedef struct packed {
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic       en;
    } stim_t;

    typedef struct packed {
        logic [7:0] count;
        logic       busy;
        logic       done;
        logic       zero;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       count_clr;
    logic       load;
    logic [7:0] load_val;
    logic       count_en;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       zero;

    int    checks;
    int    failures;
    stim_t stim_q[$];
    exp_t  exp_q[$];
    stim_t s;
    exp_t  e;

    countdown_timer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_clr (count_clr),
        .load      (load),
        .load_val  (load_val),
        .count_en  (count_en),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic clr, input logic ld, input logic [7:0] lv,
                        input logic en, input logic [7:0] c, input logic b,
                        input logic d, input logic z);
        stim_q.push_back('{clr: clr, ld: ld, lv: lv, en: en});
        exp_q.push_back('{count: c, busy: b, done: d, zero: z});
    endtask

    // Apply one stimulus entry, let one rising edge pass, settle.
    task automatic step(input stim_t st);
        count_clr = st.clr;
        load      = st.ld;
        load_val  = st.lv;
        count_en  = st.en;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; count_clr = 1'b0; load = 1'b0; load_val = 8'd0; count_en = 1'b0;
        #12;
        checks++;
        if ({count, busy, done, zero} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_init: got count=%0d busy=%b done=%b zero=%b, want 0 0 0 1",
                     count, busy, done, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step(s);
            checks++;
            if ({count, busy, done, zero} !== e) begin
                failures++;
                $display("FAIL reset_idle: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                         count, busy, done, zero, e.count, e.busy, e.done, e.zero);
            end
        end
    endtask

    task automatic test_oneshot();
        push(1'b0, 1'b1, 8'd3, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
`else
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
`endif
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step(s);
            checks++;
            if ({count, busy, done, zero} !== e) begin
                failures++;
                $display("FAIL oneshot[%0d]: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                         i, count, busy, done, zero, e.count, e.busy, e.done, e.zero);
            end
        end
    endtask

    task automatic test_gated();
        push(1'b0, 1'b1, 8'd2, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
`else
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
`endif
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step(s);
            checks++;
            if ({count, busy, done, zero} !== e) begin
                failures++;
                $display("FAIL gated[%0d]: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                         i, count, busy, done, zero, e.count, e.busy, e.done, e.zero);
            end
        end
    endtask

    task automatic test_collisions();
        push(1'b0, 1'b1, 8'd4, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0);  // load beats enable
        push(1'b1, 1'b1, 8'd9, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);  // clear beats load
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);  // IDLE ignores enable
        push(1'b0, 1'b1, 8'd2, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 8'd7, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0);  // reload masks expiry
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd6, 1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step(s);
            checks++;
            if ({count, busy, done, zero} !== e) begin
                failures++;
                $display("FAIL collide[%0d]: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                         i, count, busy, done, zero, e.count, e.busy, e.done, e.zero);
            end
        end
    endtask

    task automatic test_zero_load();
        push(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 8'd5, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);  // zero load stops a run
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step(s);
            checks++;
            if ({count, busy, done, zero} !== e) begin
                failures++;
                $display("FAIL zeroload[%0d]: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                         i, count, busy, done, zero, e.count, e.busy, e.done, e.zero);
            end
        end
    endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_autoreload();
        push(1'b0, 1'b1, 8'd3, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            push(1'b0, 1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
            push(1'b0, 1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
            push(1'b0, 1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        end
        push(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step(s);
            checks++;
            if ({count, busy, done, zero} !== e) begin
                failures++;
                $display("FAIL autoreload[%0d]: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                         i, count, busy, done, zero, e.count, e.busy, e.done, e.zero);
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        push(1'b0, 1'b1, 8'd5, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
        s = stim_q.pop_front(); e = exp_q.pop_front();
        step(s);
        checks++;
        if ({count, busy, done, zero} !== e) begin
            failures++;
            $display("FAIL async_pre: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                     count, busy, done, zero, e.count, e.busy, e.done, e.zero);
        end
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({count, busy, done, zero} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL async_now: got count=%0d busy=%b done=%b zero=%b, want 0 0 0 1",
                     count, busy, done, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        s = stim_q.pop_front(); e = exp_q.pop_front();
        step(s);
        checks++;
        if ({count, busy, done, zero} !== e) begin
            failures++;
            $display("FAIL async_post: got count=%0d busy=%b done=%b zero=%b, want count=%0d busy=%b done=%b zero=%b",
                     count, busy, done, zero, e.count, e.busy, e.done, e.zero);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_oneshot();
        test_gated();
        test_collisions();
        test_zero_load();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        test_autoreload();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_countdown_timer
